// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window fetch path: move codes, fetch FSM states, window geometry.
// Latency: n/a (types only); backpressure: n/a.
package sobel_pkg;

    localparam int WIN_N     = 3;
    localparam int WIN_PIX   = WIN_N * WIN_N;
    localparam int PIX_W_DEF = 8;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {
        DIR_NOP   = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DATA,
        ST_COMMIT,
        ST_DONE
    } fetch_state_t;

    function automatic int win_idx(input int r, input int c);
        return r * WIN_N + c;
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Maps (base, stride, move, read index) to the SRAM address of that read and the read count.
// Latency: combinational; backpressure: none.
module window_addr_gen
    import sobel_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  dir_t              dir,
    input  logic              load,
    input  logic [3:0]        idx,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        count
);

    logic [1:0]        row;
    logic [1:0]        col;
    logic [ADDR_W-1:0] row_off;

    // Loads walk the window row-major; shifts read one column (left/right) or the bottom row.
    always_comb begin
        row   = '0;
        col   = '0;
        count = '0;
        if (load) begin
            count = 4'(WIN_PIX);
            if (idx >= 4'd6) begin
                row = 2'd2;
                col = 2'(idx - 4'd6);
            end else if (idx >= 4'd3) begin
                row = 2'd1;
                col = 2'(idx - 4'd3);
            end else begin
                col = idx[1:0];
            end
        end else begin
            case (dir)
                DIR_RIGHT: begin
                    count = 4'(WIN_N);
                    row   = idx[1:0];
                    col   = 2'd2;
                end
                DIR_LEFT: begin
                    count = 4'(WIN_N);
                    row   = idx[1:0];
                end
                DIR_DOWN: begin
                    count = 4'(WIN_N);
                    row   = 2'd2;
                    col   = idx[1:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (row)
            2'd0:    row_off = '0;
            2'd1:    row_off = stride;
            default: row_off = {stride[ADDR_W-2:0], 1'b0};
        endcase
    end

    assign addr = base + row_off + ADDR_W'(col);

endmodule

// File: rtl/sobel_window_fetch.sv
// 3x3 Sobel window maintainer: full 9-read load or 3-read incremental shift, one SRAM read in flight.
// Latency 2 cycles/read + commit + done; stalls on mem_rvalid (16-cycle abort with SOBEL_FETCH_TIMEOUT_EN).
module sobel_window_fetch
    import sobel_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int PIX_W  = 8,
    parameter int DIM_W  = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIM_W-1:0]       width,
    input  logic [ADDR_W-1:0]      addr_r,
    input  logic [1:0]             direction,
    input  logic                   load_window,
    input  logic                   start_fetch,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_read,
    input  logic [PIX_W-1:0]       mem_rdata,
    input  logic                   mem_rvalid,
    output logic [WIN_PIX*PIX_W-1:0] window,
    output logic                   window_valid,
    output logic                   busy,
    output logic                   fetch_done,
    output logic                   fetch_err
);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] stride_q;
    dir_t              dir_q;
    logic              load_q;
    logic [3:0]        idx_q;
    logic [PIX_W-1:0]  stage_q [WIN_PIX];
    logic [PIX_W-1:0]  win_q   [WIN_PIX];
    logic              valid_q;
    logic              busy_q;
    logic              read_q;
    logic              done_q;
    logic [ADDR_W-1:0] gen_addr;
    logic [3:0]        gen_count;
    logic              unused_width_hi;

    assign unused_width_hi = ^width[DIM_W-1:ADDR_W];

`ifdef SOBEL_FETCH_TIMEOUT_EN
    logic [3:0] tmo_q;
    logic       err_q;
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    window_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .base   (base_q),
        .stride (stride_q),
        .dir    (dir_q),
        .load   (load_q),
        .idx    (idx_q),
        .addr   (gen_addr),
        .count  (gen_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            stride_q <= '0;
            dir_q    <= DIR_NOP;
            load_q   <= 1'b0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            read_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < WIN_PIX; i++) begin
                stage_q[i] <= '0;
                win_q[i]   <= '0;
            end
`ifdef SOBEL_FETCH_TIMEOUT_EN
            tmo_q <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            read_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SOBEL_FETCH_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (load_window || start_fetch) begin
                        base_q   <= addr_r;
                        stride_q <= width[ADDR_W-1:0];
                        dir_q    <= dir_t'(direction);
                        load_q   <= load_window;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        if (load_window) begin
                            valid_q <= 1'b0;
                        end
                        // A no-op move skips the read phase but still reports completion.
                        if (!load_window && direction == DIR_NOP) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            state_q <= ST_ISSUE;
                            read_q  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT_DATA;
`ifdef SOBEL_FETCH_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                ST_WAIT_DATA: begin
                    if (mem_rvalid) begin
                        stage_q[idx_q] <= mem_rdata;
                        if (idx_q == gen_count - 4'd1) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= ST_ISSUE;
                            read_q  <= 1'b1;
                        end
                    end
`ifdef SOBEL_FETCH_TIMEOUT_EN
                    else if (tmo_q == 4'hF) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        if (load_q) begin
                            valid_q <= 1'b0;
                        end
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
`endif
                end
                ST_COMMIT: begin
                    // The whole window moves in this one cycle; staging holds new[0..2] for shifts.
                    if (load_q) begin
                        for (int i = 0; i < WIN_PIX; i++) begin
                            win_q[i] <= stage_q[i];
                        end
                        valid_q <= 1'b1;
                    end else begin
                        for (int r = 0; r < WIN_N; r++) begin
                            case (dir_q)
                                DIR_RIGHT: begin
                                    win_q[win_idx(r, 0)] <= win_q[win_idx(r, 1)];
                                    win_q[win_idx(r, 1)] <= win_q[win_idx(r, 2)];
                                    win_q[win_idx(r, 2)] <= stage_q[r];
                                end
                                DIR_LEFT: begin
                                    win_q[win_idx(r, 2)] <= win_q[win_idx(r, 1)];
                                    win_q[win_idx(r, 1)] <= win_q[win_idx(r, 0)];
                                    win_q[win_idx(r, 0)] <= stage_q[r];
                                end
                                DIR_DOWN: begin
                                    win_q[win_idx(0, r)] <= win_q[win_idx(1, r)];
                                    win_q[win_idx(1, r)] <= win_q[win_idx(2, r)];
                                    win_q[win_idx(2, r)] <= stage_q[r];
                                end
                                default: ;
                            endcase
                        end
                    end
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        window = '0;
        for (int i = 0; i < WIN_PIX; i++) begin
            window[i*PIX_W +: PIX_W] = win_q[i];
        end
    end

    assign mem_addr     = gen_addr;
    assign mem_read     = read_q;
    assign window_valid = valid_q;
    assign busy         = busy_q;
    assign fetch_done   = done_q;

endmodule
